// File: rtl/data_mem_sequencer.sv
// data_mem_sequencer: load/store sequencer between the core datapath and a req/ack data-memory bus
// Core side: mreq/mem_write/funct3/addr/wdata in; stall, ld_data, ld_valid, misalign_err, timeout_err out.
// Bus side: bus_req/bus_we/bus_addr/bus_be/bus_wdata out; bus_ack/bus_rdata in.
module data_mem_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mreq,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [1:0] off;
  logic [2:0] f3;
  logic bad;
  logic [3:0] be_n;
  logic [31:0] wd_n, lane, ext;
  always_comb begin
    bad = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (mem_write & funct3[2]) |
          ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    be_n = (funct3[1:0] == 2'b10) ? 4'b1111 : (funct3[0] ? 4'b0011 : 4'b0001) << addr[1:0];
    wd_n = (funct3[1:0] == 2'b10) ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    lane = bus_rdata >> {off, 3'b000};
    ext  = f3[1] ? lane :
           f3[0] ? (f3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]}) :
                   (f3[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]});
    // gated by rst_n so the pipeline is released the instant reset asserts
    stall = rst_n & (((state == IDLE) & mreq) | (state == BUSY));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      off          <= 2'b00;
      f3           <= 3'b000;
      ld_data      <= 32'b0;
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'b0;
      bus_be       <= 4'b0;
      bus_wdata    <= 32'b0;
    end else begin
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: if (mreq) begin
          if (bad) begin
            state        <= DONE;
            misalign_err <= 1'b1;
          end else begin
            state     <= BUSY;
            cnt       <= '0;
            off       <= addr[1:0];
            f3        <= funct3;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_n;
            bus_wdata <= wd_n;
          end
        end
        BUSY: if (bus_ack) begin
          state   <= DONE;
          bus_req <= 1'b0;
          bus_be  <= 4'b0;
          if (!bus_we) begin
            ld_data  <= ext;
            ld_valid <= 1'b1;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state       <= DONE;
          bus_req     <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_sequencer.sv
// tb_data_mem_sequencer: table-driven scoreboard bench for data_mem_sequencer
module tb_data_mem_sequencer;
  localparam int TO = 4;
  localparam int LD = 0, ST = 1, BAD = 2, TMO = 3;
  logic clk = 0, rst_n = 0, mreq = 0, mem_write = 0, bus_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic stall, ld_valid, misalign_err, timeout_err, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int checks = 0, failures = 0;
  logic [31:0] ld_model = 0;
  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
    int wt; logic [3:0] be; logic [31:0] bwd; int kind; logic [31:0] ld;
  } vec_t;
  typedef struct { int kind; int busy; logic [31:0] ld; } exp_t;
  vec_t tv[17];
  exp_t q[$];
  data_mem_sequencer #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mreq(mreq), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .misalign_err(misalign_err), .timeout_err(timeout_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    exp_t e, g;
    int n_busy;
    bit done;
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_pulses", idx), {ld_valid, misalign_err, timeout_err}, 0);
    mreq = 1; mem_write = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    #1 chk($sformatf("v%0d stall_on_req", idx), stall, 1);
    e.kind = v.kind;
    e.busy = (v.kind == BAD) ? 0 : (v.kind == TMO) ? TO : v.wt + 1;
    if (v.kind == LD) ld_model = v.ld;
    e.ld = ld_model;
    q.push_back(e);
    n_busy = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (stall) begin
        chk($sformatf("v%0d bus_req", idx), bus_req, 1);
        if (n_busy == 0) begin
          chk($sformatf("v%0d bus_we", idx), bus_we, v.we);
          chk($sformatf("v%0d bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d bus_be", idx), bus_be, v.be);
          chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
        end
        bus_ack = (n_busy == v.wt);
        bus_rdata = v.rdata;
        n_busy++;
      end else begin
        done = 1;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL v%0d scoreboard_empty", idx);
        end else begin
          g = q.pop_front();
          chk($sformatf("v%0d busy_cycles", idx), n_busy, g.busy);
          chk($sformatf("v%0d ld_valid", idx), ld_valid, g.kind == LD);
          chk($sformatf("v%0d misalign_err", idx), misalign_err, g.kind == BAD);
          chk($sformatf("v%0d timeout_err", idx), timeout_err, g.kind == TMO);
          chk($sformatf("v%0d ld_data", idx), ld_data, g.ld);
          chk($sformatf("v%0d bus_req_done", idx), bus_req, 0);
          if (g.kind == LD || g.kind == ST) chk($sformatf("v%0d bus_be_done", idx), bus_be, 0);
        end
        mreq = 0;
        bus_ack = 0;
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL v%0d no_completion actual=stall_high required=done", idx);
      mreq = 0;
      bus_ack = 0;
    end
  endtask
  initial begin
    vec_t rv;
    int seen;
    tv[0]  = '{0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  4'hF, 32'h0,        LD,  32'hDEADBEEF};
    tv[1]  = '{0, 3'b000, 32'h203, 32'h0,        32'h80112233, 3,  4'h8, 32'h0,        LD,  32'hFFFFFF80};
    tv[2]  = '{0, 3'b100, 32'h203, 32'h0,        32'h80112233, 3,  4'h8, 32'h0,        LD,  32'h00000080};
    tv[3]  = '{1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1,  4'hC, 32'hABCDABCD, ST,  32'h0};
    tv[4]  = '{0, 3'b010, 32'h101, 32'h0,        32'h0,        0,  4'h0, 32'h0,        BAD, 32'h0};
    tv[5]  = '{0, 3'b011, 32'h100, 32'h0,        32'h0,        0,  4'h0, 32'h0,        BAD, 32'h0};
    tv[6]  = '{0, 3'b010, 32'h300, 32'h0,        32'h0,        99, 4'hF, 32'h0,        TMO, 32'h0};
    tv[7]  = '{0, 3'b010, 32'h304, 32'h0,        32'h55AA00FF, 3,  4'hF, 32'h0,        LD,  32'h55AA00FF};
    tv[8]  = '{0, 3'b001, 32'h202, 32'h0,        32'h80017FFF, 1,  4'hC, 32'h0,        LD,  32'hFFFF8001};
    tv[9]  = '{0, 3'b101, 32'h200, 32'h0,        32'h1234F00D, 2,  4'h3, 32'h0,        LD,  32'h0000F00D};
    tv[10] = '{1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        2,  4'h2, 32'hA5A5A5A5, ST,  32'h0};
    tv[11] = '{1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        0,  4'hF, 32'hCAFEF00D, ST,  32'h0};
    tv[12] = '{1, 3'b100, 32'h100, 32'h0,        32'h0,        0,  4'h0, 32'h0,        BAD, 32'h0};
    tv[13] = '{0, 3'b001, 32'h201, 32'h0,        32'h0,        0,  4'h0, 32'h0,        BAD, 32'h0};
    tv[14] = '{0, 3'b000, 32'h201, 32'h0,        32'h00007F00, 0,  4'h2, 32'h0,        LD,  32'h0000007F};
    tv[15] = '{0, 3'b110, 32'h100, 32'h0,        32'h0,        0,  4'h0, 32'h0,        BAD, 32'h0};
    tv[16] = '{0, 3'b010, 32'h400, 32'h0,        32'h01020304, 3,  4'hF, 32'h0,        LD,  32'h01020304};
    repeat (2) @(negedge clk);
    chk("rst bus_req", bus_req, 0);
    chk("rst stall", stall, 0);
    chk("rst pulses", {ld_valid, misalign_err, timeout_err}, 0);
    chk("rst ld_data", ld_data, 0);
    chk("rst bus_be", bus_be, 0);
    rst_n = 1;
    for (int i = 0; i < 17; i++) run(tv[i], i);
    @(posedge clk); #1;
    mreq = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h500; wdata = 0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(posedge clk); #1;
      if (bus_req) seen++;
    end
    chk("midbusy reached", seen, 2);
    #2 rst_n = 0;
    #1;
    chk("midbusy bus_req", bus_req, 0);
    chk("midbusy stall", stall, 0);
    chk("midbusy pulses", {ld_valid, misalign_err, timeout_err}, 0);
    chk("midbusy bus_be", bus_be, 0);
    chk("midbusy ld_data", ld_data, 0);
    ld_model = 0;
    @(negedge clk);
    rst_n = 1;
    mreq = 0;
    rv = '{0, 3'b010, 32'h500, 32'h0, 32'h13579BDF, 1, 4'hF, 32'h0, LD, 32'h13579BDF};
    run(rv, 17);
    chk("scoreboard drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_sequencer.md
Name: data_mem_sequencer

Overview:
- Multi-cycle sequencer between the core datapath and the data-memory bus for load/store instructions (decoder asserts mreq).
- Latches the access, drives a req/ack bus handshake with per-lane byte enables, and stalls the pipeline until completion.
- Returns sign/zero-extended load data and flags misaligned, illegal or timed-out accesses.
- Sits between the ALU result / register-file read port and the external data RAM.

Parameters:
- TIMEOUT, 16, max BUSY cycles without bus_ack before abort (>=1).
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mreq  in  1  current instruction is a load/store (decoder output).
- mem_write  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and pipeline registers.
- ld_data  out  32  extended load result.
- ld_valid  out  1  one-cycle pulse: ld_data updated.
- misalign_err  out  1  one-cycle pulse: misaligned or illegal funct3.
- timeout_err  out  1  one-cycle pulse: bus did not ack.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word address: {addr[31:2], 2'b00}.
- bus_be  out  4  byte-lane enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completion, sampled only while bus_req=1.
- bus_rdata  in  32  read word, valid with bus_ack.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Timeout counter 0. Takes effect immediately, including mid-BUSY: bus_req drops without waiting for ack.
- States:
  - IDLE -> BUSY on mreq and legal access.
  - IDLE -> DONE on mreq and bad access; no bus cycle.
  - BUSY -> DONE on bus_ack or timeout.
  - DONE -> IDLE unconditionally, after exactly one cycle.
- stall (combinational) = (IDLE & mreq) | BUSY. It is 0 in DONE, so the pipeline advances on the DONE cycle edge. The held mreq is therefore never re-served.
- Bad access:
  - funct3 not in {000,001,010,100,101}, or store with funct3[2]=1.
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
- IDLE->BUSY edge latches:
  - bus_we=mem_write, bus_addr, lane offset addr[1:0], funct3.
  - bus_be: b = 0001<<off; h = 0011<<off; w = 1111. Loads use the same enables.
  - bus_wdata: sb = {4{wdata[7:0]}}; sh = {2{wdata[15:0]}}; sw = wdata.
  - bus_req <= 1.
- Bus side: bus_req and bus fields are held stable while in BUSY. On bus_ack=1: bus_req <= 0, bus_be <= 0, go DONE. bus_ack with bus_req=0 is ignored.
- Timeout: counter clears on entering BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT-1 without ack: bus_req <= 0, go DONE, timeout_err=1 in DONE. Ack in that same cycle wins (normal completion, no error).
- Load data: captured on ack as lane = bus_rdata >> (8*off).
  - lb: sign-extend lane[7:0]; lbu: zero-extend lane[7:0].
  - lh: sign-extend lane[15:0]; lhu: zero-extend lane[15:0].
  - lw: full word.
  - ld_data is registered, held until the next successful load, and not updated on store, error or timeout.
- Pulses in DONE (one cycle):
  - ld_valid=1 for a successful load.
  - misalign_err=1 for a bad access.
  - timeout_err=1 for a timeout.
  - At most one of the three is set.
- Stores: no ld_valid; completion is signalled only by stall falling.
- Back-to-back accesses: a new mreq is accepted in the first IDLE cycle after DONE. Minimum 3 cycles per access with zero-wait ack.

Test Plan:
- lw addr=0x100, bus_ack in first BUSY cycle, rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, stall high 2 cycles, ld_valid pulse, ld_data=0xDEADBEEF.
- lb addr=0x203, rdata=0x80112233, ack after 3 wait cycles -> bus_be=1000, ld_data=0xFFFFFF80. Same with lbu -> 0x00000080.
- sh addr=0x102, wdata=0x1234ABCD -> bus_we=1, bus_addr=0x100, bus_be=1100, bus_wdata=0xABCDABCD, no ld_valid.
- lw addr=0x101, then funct3=011 -> no bus_req, misalign_err pulse each, stall exactly 1 cycle, ld_data unchanged.
- TIMEOUT=4, lw with bus_ack never asserted -> bus_req high 4 cycles then 0, timeout_err pulse. Repeat with ack in the 4th cycle -> ld_valid, no timeout_err.
- rst_n=0 in 2nd BUSY cycle -> bus_req, stall and all pulses 0 immediately; after release, the new mreq is served normally.
